// File: rtl/bnn_neuron_seq.sv
// bnn_neuron_seq: streams XNOR'd activation/weight words to the shared popcount
// unit, accumulates its signed results with saturation and emits one activation
// bit per neuron once every issued word has come back.
module bnn_neuron_seq #(
   parameter int unsigned ACC_W     = 16,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_val,
   output logic             s_rdy,
   input  logic [63:0]      s_act,
   input  logic [63:0]      s_wgt,
   input  logic             s_last,
   input  logic [ACC_W-1:0] s_thr,
   output logic             i_val,
   output logic [63:0]      stream_i,
   input  logic             o_val,
   input  logic [7:0]       stream_o,
   output logic             m_val,
   input  logic             m_rdy,
   output logic             m_bit,
   output logic [ACC_W-1:0] m_acc,
   output logic             m_err
);

   localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

   state_e           state_q, state_d;
   logic             i_val_q, i_val_d;
   logic [63:0]      stream_q, stream_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] returned_q, returned_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] thr_q, thr_d;
   logic             err_q, err_d;
   logic             m_val_q, m_val_d;
   logic             m_bit_q, m_bit_d;
   logic [ACC_W-1:0] m_acc_q, m_acc_d;
   logic             m_err_q, m_err_d;

   logic             xfer;
   logic [CNT_W-1:0] issued_inc;
   logic             hit_max;
   logic [CNT_W-1:0] ret_next;
   logic [ACC_W:0]   acc_add;
   logic [ACC_W-1:0] acc_sat;

   // Ready only while collecting words; forced low during reset.
   assign s_rdy = !rst && ((state_q == IDLE) || (state_q == ISSUE));
   assign xfer  = s_val && s_rdy;

   // Word count after this transfer, result count including this cycle's arrival.
   assign issued_inc = (state_q == IDLE) ? CNT_W'(1) : issued_q + CNT_W'(1);
   assign hit_max    = (issued_inc == MAX_CNT);
   assign ret_next   = returned_q + CNT_W'(o_val);

   // Sign-extended add with one guard bit, clamped to the signed accumulator range.
   always_comb begin
      acc_add = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){stream_o[7]}}, stream_o};
      acc_sat = acc_add[ACC_W-1:0];
      if (acc_add[ACC_W] != acc_add[ACC_W-1]) begin
         acc_sat = acc_add[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   // Next-state, counters, accumulator and result capture.
   always_comb begin
      state_d    = state_q;
      i_val_d    = xfer;
      stream_d   = stream_q;
      issued_d   = issued_q;
      returned_d = returned_q;
      acc_d      = acc_q;
      thr_d      = thr_q;
      err_d      = err_q;
      m_val_d    = m_val_q;
      m_bit_d    = m_bit_q;
      m_acc_d    = m_acc_q;
      m_err_d    = m_err_q;

      if (xfer) begin
         stream_d = ~(s_act ^ s_wgt);
      end

      // Results are only meaningful while a neuron is in flight.
      if (((state_q == ISSUE) || (state_q == DRAIN)) && o_val) begin
         acc_d      = acc_sat;
         returned_d = ret_next;
      end

      case (state_q)
         IDLE: begin
            if (xfer) begin
               acc_d      = '0;
               thr_d      = s_thr;
               issued_d   = issued_inc;
               returned_d = '0;
               err_d      = hit_max && !s_last;
               state_d    = (s_last || hit_max) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (xfer) begin
               issued_d = issued_inc;
               if (s_last || hit_max) begin
                  err_d   = !s_last;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (ret_next == issued_q) begin
               m_val_d = 1'b1;
               m_acc_d = acc_d;
               m_bit_d = $signed(acc_d) >= $signed(thr_q);
               m_err_d = err_q;
               state_d = OUT;
            end
         end
         OUT: begin
            if (m_rdy) begin
               m_val_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         i_val_q    <= 1'b0;
         stream_q   <= '0;
         issued_q   <= '0;
         returned_q <= '0;
         acc_q      <= '0;
         thr_q      <= '0;
         err_q      <= 1'b0;
         m_val_q    <= 1'b0;
         m_bit_q    <= 1'b0;
         m_acc_q    <= '0;
         m_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_val_q    <= i_val_d;
         stream_q   <= stream_d;
         issued_q   <= issued_d;
         returned_q <= returned_d;
         acc_q      <= acc_d;
         thr_q      <= thr_d;
         err_q      <= err_d;
         m_val_q    <= m_val_d;
         m_bit_q    <= m_bit_d;
         m_acc_q    <= m_acc_d;
         m_err_q    <= m_err_d;
      end
   end

   assign i_val    = i_val_q;
   assign stream_i = stream_q;
   assign m_val    = m_val_q;
   assign m_bit    = m_bit_q;
   assign m_acc    = m_acc_q;
   assign m_err    = m_err_q;

endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Bench for bnn_neuron_seq: three instances (default, 8-bit accumulator,
// 4-word limit) each fed by a two-stage popcount model; a scoreboard holds
// expected stream words and neuron results.
module tb_bnn_neuron_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   int          sel;
   logic        s_val_drv, m_rdy_drv;
   logic [63:0] s_act, s_wgt;
   logic        s_last;
   logic [15:0] s_thr;

   logic        s_val [3];
   logic        s_rdy [3];
   logic        i_val [3];
   logic [63:0] stream_i [3];
   logic        o_val [3];
   logic [7:0]  stream_o [3];
   logic        m_val [3];
   logic        m_rdy [3];
   logic        m_bit [3];
   logic        m_err [3];
   logic [15:0] m_acc0, m_acc2;
   logic [7:0]  m_acc1;

   logic        p1_v [3];
   logic [7:0]  p1_d [3];

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] exp_stream [$];
   logic [17:0] exp_res [$];

   int   mdl_acc, mdl_thr, mdl_cnt;
   logic push_en;

   assign s_val[0] = s_val_drv && (sel == 0);
   assign s_val[1] = s_val_drv && (sel == 1);
   assign s_val[2] = s_val_drv && (sel == 2);
   assign m_rdy[0] = (sel == 0) ? m_rdy_drv : 1'b1;
   assign m_rdy[1] = (sel == 1) ? m_rdy_drv : 1'b1;
   assign m_rdy[2] = (sel == 2) ? m_rdy_drv : 1'b1;

   bnn_neuron_seq u0 (
      .clk(clk), .rst(rst), .s_val(s_val[0]), .s_rdy(s_rdy[0]), .s_act(s_act), .s_wgt(s_wgt),
      .s_last(s_last), .s_thr(s_thr), .i_val(i_val[0]), .stream_i(stream_i[0]),
      .o_val(o_val[0]), .stream_o(stream_o[0]), .m_val(m_val[0]), .m_rdy(m_rdy[0]),
      .m_bit(m_bit[0]), .m_acc(m_acc0), .m_err(m_err[0]));

   bnn_neuron_seq #(.ACC_W(8)) u1 (
      .clk(clk), .rst(rst), .s_val(s_val[1]), .s_rdy(s_rdy[1]), .s_act(s_act), .s_wgt(s_wgt),
      .s_last(s_last), .s_thr(s_thr[7:0]), .i_val(i_val[1]), .stream_i(stream_i[1]),
      .o_val(o_val[1]), .stream_o(stream_o[1]), .m_val(m_val[1]), .m_rdy(m_rdy[1]),
      .m_bit(m_bit[1]), .m_acc(m_acc1), .m_err(m_err[1]));

   bnn_neuron_seq #(.MAX_WORDS(4)) u2 (
      .clk(clk), .rst(rst), .s_val(s_val[2]), .s_rdy(s_rdy[2]), .s_act(s_act), .s_wgt(s_wgt),
      .s_last(s_last), .s_thr(s_thr), .i_val(i_val[2]), .stream_i(stream_i[2]),
      .o_val(o_val[2]), .stream_o(stream_o[2]), .m_val(m_val[2]), .m_rdy(m_rdy[2]),
      .m_bit(m_bit[2]), .m_acc(m_acc2), .m_err(m_err[2]));

   function automatic logic [7:0] pcnt_res(input logic [63:0] x);
      return 8'(2 * $countones(x) - 64);
   endfunction

   // Popcount stand-in: two-cycle latency, flushed by the shared reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            p1_v[k]     <= 1'b0;
            p1_d[k]     <= '0;
            o_val[k]    <= 1'b0;
            stream_o[k] <= '0;
         end else begin
            p1_v[k]     <= i_val[k];
            p1_d[k]     <= pcnt_res(stream_i[k]);
            o_val[k]    <= p1_v[k];
            stream_o[k] <= p1_d[k];
         end
      end
   end

   // View of the instance under test.
   logic        s_rdy_sel, i_val_sel, m_val_sel, m_rdy_sel, m_bit_sel, m_err_sel;
   logic [63:0] stream_i_sel;
   logic [15:0] obs_acc;
   always_comb begin
      s_rdy_sel    = s_rdy[sel];
      i_val_sel    = i_val[sel];
      m_val_sel    = m_val[sel];
      m_rdy_sel    = m_rdy[sel];
      m_bit_sel    = m_bit[sel];
      m_err_sel    = m_err[sel];
      stream_i_sel = stream_i[sel];
      case (sel)
         1:       obs_acc = {{8{m_acc1[7]}}, m_acc1};
         2:       obs_acc = m_acc2;
         default: obs_acc = m_acc0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int x);
      int lo, hi;
      lo = (sel == 1) ? -128 : -32768;
      hi = (sel == 1) ? 127 : 32767;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   // Drive one word pair, wait for acceptance, update the reference model.
   task automatic send_word(input logic [63:0] a, input logic [63:0] w, input logic last,
                            input int thr, input int gap);
      bit got;
      int v, maxw;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
      s_act     = a;
      s_wgt     = w;
      s_last    = last;
      s_thr     = 16'(thr);
      s_val_drv = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_rdy_sel) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("s_rdy_timeout", 64'(0), 64'(1));
         s_val_drv = 1'b0;
         return;
      end
      maxw = (sel == 2) ? 4 : 256;
      v = 2 * $countones(~(a ^ w)) - 64;
      if (mdl_cnt == 0) begin
         mdl_acc = 0;
         mdl_thr = thr;
      end
      mdl_acc = sat(mdl_acc + v);
      mdl_cnt++;
      exp_stream.push_back(~(a ^ w));
      if (last || mdl_cnt == maxw) begin
         if (push_en) exp_res.push_back({mdl_acc >= mdl_thr, !last, 16'(mdl_acc)});
         mdl_cnt = 0;
      end
      @(posedge clk);
      #1;
      s_val_drv = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_res.size() != 0; i++) @(posedge clk);
      if (exp_res.size() != 0) begin
         chk("drain_timeout", 64'(exp_res.size()), 64'(0));
         exp_res.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Output monitor: stream words and neuron results against the scoreboard.
   always @(negedge clk) begin
      logic [17:0] e;
      if (!rst) begin
         if (i_val_sel) begin
            if (exp_stream.size() == 0) chk("i_val_spurious", 64'(1), 64'(0));
            else chk("stream_i", stream_i_sel, exp_stream.pop_front());
         end
         if (m_val_sel) begin
            if (exp_res.size() == 0) chk("m_val_spurious", 64'(1), 64'(0));
            else begin
               e = exp_res[0];
               chk("m_bit", 64'(m_bit_sel), 64'(e[17]));
               chk("m_err", 64'(m_err_sel), 64'(e[16]));
               chk("m_acc", 64'(obs_acc), 64'(e[15:0]));
               if (m_rdy_sel) void'(exp_res.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a;
      int thr;
      rst = 1'b1; sel = 0; s_val_drv = 1'b0; m_rdy_drv = 1'b1;
      s_act = '0; s_wgt = '0; s_last = 1'b0; s_thr = '0;
      mdl_acc = 0; mdl_thr = 0; mdl_cnt = 0; push_en = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_rdy", 64'(s_rdy_sel), 64'(0));
      chk("rst_m_val", 64'(m_val_sel), 64'(0));
      chk("rst_i_val", 64'(i_val_sel), 64'(0));
      chk("rst_m_acc", 64'(obs_acc), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_s_rdy", 64'(s_rdy_sel), 64'(1));
      @(posedge clk);
      #1;

      // Single all-match word.
      send_word('1, '1, 1'b1, 64, 0);
      drain();

      // Four fully mismatched words.
      for (int i = 0; i < 4; i++) begin
         a = {$urandom, $urandom};
         send_word(a, ~a, i == 3, 0, 0);
      end
      drain();

      // Random words with gaps, result held while m_rdy low.
      m_rdy_drv = 1'b0;
      thr = int'($urandom_range(0, 400)) - 200;
      for (int i = 0; i < 16; i++) begin
         a = {$urandom, $urandom};
         send_word(a, {$urandom, $urandom}, i == 15, thr, int'($urandom_range(0, 2)));
      end
      for (int i = 0; i < 100 && !m_val_sel; i++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1 m_rdy_drv = 1'b1;
      drain();

      // 8-bit accumulator saturation.
      sel = 1;
      for (int i = 0; i < 4; i++) begin
         a = {$urandom, $urandom};
         send_word(a, a, i == 3, 127, 0);
      end
      drain();

      // Truncation at the word limit, remainder forms the next neuron.
      sel = 2;
      for (int i = 0; i < 6; i++) begin
         a = {$urandom, $urandom};
         send_word(a, {$urandom, $urandom}, i == 5, -10, 0);
      end
      drain();

      // Reset while draining discards the neuron.
      sel = 0;
      push_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = {$urandom, $urandom};
         send_word(a, {$urandom, $urandom}, i == 2, 0, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rst_drain_s_rdy", 64'(s_rdy_sel), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_stream.delete();
      mdl_cnt = 0;
      push_en = 1'b1;
      @(negedge clk);
      chk("post_rst_s_rdy", 64'(s_rdy_sel), 64'(1));
      repeat (6) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         a = {$urandom, $urandom};
         send_word(a, {$urandom, $urandom}, i == 1, 5, 0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
